rtu_pst_preg_alloc: RTL and testbench

Physical-register allocator for the PST: the controlling end of the per-entry `x_pre_alloc_vld` / `x_alloc_vld` handshake. It scans the 64 per-entry DEALLOC flags, pre-allocates the lowest free preg(s) into a 2-slot ready buffer (pulsing `x_pre_alloc_vld` so each chosen entry enters WF_ALLOC), and hands the head preg to IDU. On an IDU dispatch it pulses that entry's `x_alloc_vld`. It sits in RTU between the PST entry array and the IDU IR stage.

---
 rtl/rtu_pst_preg_alloc_pkg.sv | 23 ++
 rtl/rtu_pst_preg_alloc_if.sv | 37 +++
 rtl/rtu_pst_preg_alloc_ff1.sv | 22 ++
 rtl/rtu_pst_preg_alloc.sv | 112 +++++++++++
 tb/tb_rtu_pst_preg_alloc.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/rtu_pst_preg_alloc_pkg.sv
// Shared constants and types for the PST physical-register allocator.
package rtu_pst_preg_alloc_pkg;

    localparam int PREG_NUM = 64;
    localparam int PREG_W   = 6;

    // Ready-buffer occupancy encoding (one-hot)
    localparam logic [2:0] ST_EMPTY = 3'b001;
    localparam logic [2:0] ST_ONE   = 3'b010;
    localparam logic [2:0] ST_FULL  = 3'b100;

    typedef logic [PREG_W-1:0]   preg_idx_t;
    typedef logic [PREG_NUM-1:0] preg_vec_t;

    // One-hot vector with only bit idx set
    function automatic preg_vec_t pregOneHot(input preg_idx_t idx);
        preg_vec_t v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rtu_pst_preg_alloc_if.sv
// Handshake bundle between the allocator, the PST entry array and IDU.
// The master side is the allocator; the slave side is the entries/IDU.
interface rtu_pst_preg_alloc_if;
    import rtu_pst_preg_alloc_pkg::*;

    preg_vec_t x_preg_dealloc_vec;
    logic      rtu_global_flush;
    logic      idu_rtu_alloc_req;
    preg_vec_t x_pre_alloc_vld_vec;
    preg_vec_t x_alloc_vld_vec;
    logic      rtu_idu_alloc_vld;
    preg_idx_t rtu_idu_alloc_preg;
    logic      rtu_idu_preg_full;

    modport master (
        input  x_preg_dealloc_vec,
        input  rtu_global_flush,
        input  idu_rtu_alloc_req,
        output x_pre_alloc_vld_vec,
        output x_alloc_vld_vec,
        output rtu_idu_alloc_vld,
        output rtu_idu_alloc_preg,
        output rtu_idu_preg_full
    );

    modport slave (
        output x_preg_dealloc_vec,
        output rtu_global_flush,
        output idu_rtu_alloc_req,
        input  x_pre_alloc_vld_vec,
        input  x_alloc_vld_vec,
        input  rtu_idu_alloc_vld,
        input  rtu_idu_alloc_preg,
        input  rtu_idu_preg_full
    );

endinterface

// File: rtl/rtu_pst_preg_alloc_ff1.sv
// 64-bit find-first-one: index of the lowest set bit plus a found flag.
module rtu_preg_ff1_64
    import rtu_pst_preg_alloc_pkg::*;
(
    input  preg_vec_t vec_i,
    output preg_idx_t idx_o,
    output logic      found_o
);

    // Scan from the top down so the lowest set bit is the last one written
    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        for (int i = PREG_NUM - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o   = PREG_W'(i);
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rtu_pst_preg_alloc.sv
// Physical-register allocator: pre-allocates the lowest free pregs into a
// two-slot ready buffer and hands the head slot to IDU on dispatch.
module rtu_pst_preg_alloc
    import rtu_pst_preg_alloc_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_clk,
    rtu_pst_preg_alloc_if.master  bus
);

    logic [2:0] state_q, state_d;
    preg_idx_t  slot0_q, slot0_d;
    preg_idx_t  slot1_q, slot1_d;

    preg_vec_t  heldMask;
    preg_vec_t  candVec;
    preg_idx_t  candIdx;
    logic       candFound;
    logic       flush;
    logic       push;
    logic       pop;

    assign flush = bus.rtu_global_flush;

    // Entries already sitting in the buffer are masked out of the search;
    // they should already be WF_ALLOC, so this only guards against stale bits
    always_comb begin
        heldMask = '0;
        if (state_q != ST_EMPTY) begin
            heldMask = heldMask | pregOneHot(slot0_q);
        end
        if (state_q == ST_FULL) begin
            heldMask = heldMask | pregOneHot(slot1_q);
        end
    end

    assign candVec = bus.x_preg_dealloc_vec & ~heldMask;

    rtu_preg_ff1_64 u_ff1 (
        .vec_i   (candVec),
        .idx_o   (candIdx),
        .found_o (candFound)
    );

    // Pulses are suppressed while reset is held so outputs sit at reset values
    assign push = candFound && (state_q != ST_FULL) && !flush && !rst_clk;
    assign pop  = bus.idu_rtu_alloc_req && (state_q != ST_EMPTY) && !flush && !rst_clk;

    // Occupancy FSM and slot shifting; flush empties the buffer outright
    always_comb begin
        state_d = state_q;
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        if (flush) begin
            state_d = ST_EMPTY;
            slot0_d = '0;
            slot1_d = '0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (push) begin
                        state_d = ST_ONE;
                        slot0_d = candIdx;
                    end
                end
                ST_ONE: begin
                    if (push && pop) begin
                        slot0_d = candIdx;
                    end else if (push) begin
                        state_d = ST_FULL;
                        slot1_d = candIdx;
                    end else if (pop) begin
                        state_d = ST_EMPTY;
                        slot0_d = '0;
                    end
                end
                ST_FULL: begin
                    if (pop) begin
                        state_d = ST_ONE;
                        slot0_d = slot1_q;
                        slot1_d = '0;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                    slot0_d = '0;
                    slot1_d = '0;
                end
            endcase
        end
    end

    // Buffer state registers with asynchronous return to EMPTY
    always_ff @(posedge clk or posedge rst_clk) begin
        if (rst_clk) begin
            state_q <= ST_EMPTY;
            slot0_q <= '0;
            slot1_q <= '0;
        end else begin
            state_q <= state_d;
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
        end
    end

    assign bus.x_pre_alloc_vld_vec = push ? pregOneHot(candIdx) : '0;
    assign bus.x_alloc_vld_vec     = pop  ? pregOneHot(slot0_q) : '0;
    assign bus.rtu_idu_alloc_vld   = (state_q != ST_EMPTY) && !flush && !rst_clk;
    assign bus.rtu_idu_alloc_preg  = slot0_q;
    assign bus.rtu_idu_preg_full   = (state_q == ST_EMPTY) && ~|bus.x_preg_dealloc_vec;

endmodule

// File: tb/tb_rtu_pst_preg_alloc.sv
// Directed testbench for the PST physical-register allocator.
module tb_rtu_pst_preg_alloc;
    import rtu_pst_preg_alloc_pkg::*;

    logic clk;
    logic rst_clk;
    int   checkCount;
    int   errorCount;

    rtu_pst_preg_alloc_if bus ();

    rtu_pst_preg_alloc dut (
        .clk     (clk),
        .rst_clk (rst_clk),
        .bus     (bus)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts and reports mismatches
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Drive control inputs at the falling edge and let combinational outputs settle
    task automatic applyStimulus(input logic req, input logic flush);
        bus.idu_rtu_alloc_req = req;
        bus.rtu_global_flush  = flush;
        #1;
    endtask

    // Advance one cycle; the entry model drops DEALLOC for any pre-allocated entry
    task automatic stepCycle();
        logic [63:0] pre;
        pre = bus.x_pre_alloc_vld_vec;
        @(posedge clk);
        #1;
        bus.x_preg_dealloc_vec = bus.x_preg_dealloc_vec & ~pre;
        @(negedge clk);
    endtask

    function automatic logic [63:0] bitOf(input int i);
        logic [63:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    initial begin
        checkCount = 0;
        errorCount = 0;
        rst_clk = 1'b1;
        bus.x_preg_dealloc_vec = '0;
        bus.idu_rtu_alloc_req  = 1'b0;
        bus.rtu_global_flush   = 1'b0;
        @(negedge clk);

        // Reset values, with and without free pregs
        applyStimulus(1'b0, 1'b0);
        checkOutput("rst_full_empty_vec", 64'(bus.rtu_idu_preg_full), 64'd1);
        bus.x_preg_dealloc_vec = 64'hFFFF_FFFF_0000_0000;
        applyStimulus(1'b1, 1'b0);
        checkOutput("rst_pre", bus.x_pre_alloc_vld_vec, 64'd0);
        checkOutput("rst_alloc", bus.x_alloc_vld_vec, 64'd0);
        checkOutput("rst_vld", 64'(bus.rtu_idu_alloc_vld), 64'd0);
        checkOutput("rst_preg", 64'(bus.rtu_idu_alloc_preg), 64'd0);
        checkOutput("rst_full", 64'(bus.rtu_idu_preg_full), 64'd0);

        // Fill from upper half: 32 then 33
        rst_clk = 1'b0;
        applyStimulus(1'b0, 1'b0);
        checkOutput("fill_pre32", bus.x_pre_alloc_vld_vec, bitOf(32));
        checkOutput("fill_vld0", 64'(bus.rtu_idu_alloc_vld), 64'd0);
        stepCycle();
        applyStimulus(1'b0, 1'b0);
        checkOutput("fill_pre33", bus.x_pre_alloc_vld_vec, bitOf(33));
        checkOutput("fill_vld1", 64'(bus.rtu_idu_alloc_vld), 64'd1);
        checkOutput("fill_preg32", 64'(bus.rtu_idu_alloc_preg), 64'd32);
        stepCycle();
        applyStimulus(1'b0, 1'b0);
        checkOutput("full_no_pre", bus.x_pre_alloc_vld_vec, 64'd0);
        checkOutput("full_state", 64'(dut.state_q), 64'(ST_FULL));

        // Back-to-back allocation with request held: 32, 33, 34
        applyStimulus(1'b1, 1'b0);
        checkOutput("pop0_alloc", bus.x_alloc_vld_vec, bitOf(32));
        checkOutput("pop0_preg", 64'(bus.rtu_idu_alloc_preg), 64'd32);
        checkOutput("pop0_pre", bus.x_pre_alloc_vld_vec, 64'd0);
        stepCycle();
        applyStimulus(1'b1, 1'b0);
        checkOutput("pop1_alloc", bus.x_alloc_vld_vec, bitOf(33));
        checkOutput("pop1_preg", 64'(bus.rtu_idu_alloc_preg), 64'd33);
        checkOutput("pop1_pre", bus.x_pre_alloc_vld_vec, bitOf(34));
        stepCycle();
        applyStimulus(1'b1, 1'b0);
        checkOutput("pop2_alloc", bus.x_alloc_vld_vec, bitOf(34));
        checkOutput("pop2_preg", 64'(bus.rtu_idu_alloc_preg), 64'd34);
        checkOutput("pop2_pre", bus.x_pre_alloc_vld_vec, bitOf(35));
        stepCycle();
        applyStimulus(1'b0, 1'b0);
        checkOutput("pop3_preg", 64'(bus.rtu_idu_alloc_preg), 64'd35);

        // Flush while holding preg 40
        rst_clk = 1'b1;
        bus.x_preg_dealloc_vec = bitOf(40);
        applyStimulus(1'b0, 1'b0);
        rst_clk = 1'b0;
        applyStimulus(1'b0, 1'b0);
        checkOutput("fl_pre40", bus.x_pre_alloc_vld_vec, bitOf(40));
        stepCycle();
        applyStimulus(1'b1, 1'b1);
        checkOutput("fl_alloc", bus.x_alloc_vld_vec, 64'd0);
        checkOutput("fl_pre", bus.x_pre_alloc_vld_vec, 64'd0);
        checkOutput("fl_vld", 64'(bus.rtu_idu_alloc_vld), 64'd0);
        stepCycle();
        checkOutput("fl_state", 64'(dut.state_q), 64'(ST_EMPTY));

        // Empty with nothing free: request is ignored
        applyStimulus(1'b1, 1'b0);
        checkOutput("emp_alloc", bus.x_alloc_vld_vec, 64'd0);
        checkOutput("emp_pre", bus.x_pre_alloc_vld_vec, 64'd0);
        checkOutput("emp_vld", 64'(bus.rtu_idu_alloc_vld), 64'd0);
        checkOutput("emp_full", 64'(bus.rtu_idu_preg_full), 64'd1);
        bus.x_preg_dealloc_vec = bitOf(5);
        applyStimulus(1'b1, 1'b0);
        checkOutput("b5_pre", bus.x_pre_alloc_vld_vec, bitOf(5));
        checkOutput("b5_full", 64'(bus.rtu_idu_preg_full), 64'd0);
        checkOutput("b5_alloc", bus.x_alloc_vld_vec, 64'd0);
        stepCycle();
        applyStimulus(1'b1, 1'b0);
        checkOutput("b5_vld", 64'(bus.rtu_idu_alloc_vld), 64'd1);
        checkOutput("b5_preg", 64'(bus.rtu_idu_alloc_preg), 64'd5);
        checkOutput("b5_alloc5", bus.x_alloc_vld_vec, bitOf(5));
        stepCycle();

        // Async reset in the middle of a cycle while FULL {10,11}
        bus.x_preg_dealloc_vec = bitOf(10) | bitOf(11) | bitOf(12);
        applyStimulus(1'b0, 1'b0);
        stepCycle();
        applyStimulus(1'b0, 1'b0);
        stepCycle();
        applyStimulus(1'b1, 1'b0);
        checkOutput("ar_state_full", 64'(dut.state_q), 64'(ST_FULL));
        checkOutput("ar_alloc10", bus.x_alloc_vld_vec, bitOf(10));
        #1;
        rst_clk = 1'b1;
        #1;
        checkOutput("ar_alloc", bus.x_alloc_vld_vec, 64'd0);
        checkOutput("ar_pre", bus.x_pre_alloc_vld_vec, 64'd0);
        checkOutput("ar_vld", 64'(bus.rtu_idu_alloc_vld), 64'd0);
        checkOutput("ar_preg", 64'(bus.rtu_idu_alloc_preg), 64'd0);
        checkOutput("ar_full", 64'(bus.rtu_idu_preg_full), 64'd0);
        checkOutput("ar_state", 64'(dut.state_q), 64'(ST_EMPTY));
        @(negedge clk);
        rst_clk = 1'b0;
        applyStimulus(1'b0, 1'b0);
        checkOutput("ar_pre12", bus.x_pre_alloc_vld_vec, bitOf(12));

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
